jpc_memarb: RTL and testbench
=============================

JPC_MEMARB -- requirements
Module: jpc_memarb

Interface
REQ-001 Parameter ADDRESS_WIDTH, default `JPC_ADDRESS_WIDTH` (32): width of every address port.
REQ-002 Parameter DATA_WIDTH, default `JPC_MEMDATA_WIDTH` (32): width of every data port.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 req0_addr_I  in  ADDRESS_WIDTH  port 0 (instruction fetch) read address.
REQ-006 req0_valid_I / req0_ready_O  in / out  1  port 0 request handshake.
REQ-007 rsp0_data_O  out  DATA_WIDTH  port 0 read data.
REQ-008 rsp0_valid_O / rsp0_ready_I  out / in  1  port 0 response handshake.
REQ-009 flush0_I  in  1  port 0 redirect: cancel port 0 outstanding transaction.
REQ-010 req1_addr_I, req1_valid_I, req1_ready_O, rsp1_data_O, rsp1_valid_O, rsp1_ready_I: port 1 (data load) equivalents of REQ-005..REQ-008.
REQ-011 mem_addr_O  out  ADDRESS_WIDTH  shared memory address.
REQ-012 mem_addr_valid_O / mem_addr_ready_I  out / in  1  memory address handshake.
REQ-013 mem_data_I  in  DATA_WIDTH  memory read data.
REQ-014 mem_data_valid_I / mem_data_ready_O  in / out  1  memory data handshake.
REQ-015 grant_O  out  1  owner of current transaction (0 = port 0, 1 = port 1); valid outside IDLE.

Function
REQ-016 Transfers SHALL occur on a rising edge where valid and ready are both 1; a valid, once asserted, stays asserted with stable payload until accepted.
REQ-017 FSM states SHALL be IDLE, ADDR, DATA, RESP; at most one transaction outstanding.
REQ-018 IDLE: if exactly one reqN_valid_I is 1, that port wins; if both, the port not granted last wins (round-robin on last_grant).
REQ-019 IDLE: reqN_ready_O SHALL be 1 combinationally for the winner only; all other req ready outputs are 0 in all states.
REQ-020 On acceptance: capture address and owner into registers; go to ADDR.
REQ-021 ADDR: mem_addr_valid_O = 1, mem_addr_O = captured address; on mem_addr_ready_I go to DATA.
REQ-022 DATA: mem_data_ready_O = 1; on mem_data_valid_I capture mem_data_I into response register; go to RESP, or to IDLE if discard flag set.
REQ-023 RESP: rspN_valid_O = 1 for owner only, rspN_data_O = response register; on rspN_ready_I go to IDLE, last_grant <= owner.
REQ-024 Minimum latency: request accept edge T, mem address accepted T+1, data captured T+2, response valid from T+2 to T+3 edge (zero memory wait states, immediate readys).
REQ-025 flush0_I when owner = 0: in ADDR or DATA set discard flag, finish memory handshakes, return to IDLE without rsp0_valid_O; in RESP drop response, go to IDLE next edge.
REQ-026 flush0_I in IDLE SHALL suppress port 0 acceptance that cycle; flush0_I has no effect when owner = 1.
REQ-027 Discarded transaction SHALL still update last_grant <= 0.
REQ-028 rsp data outputs of the non-owner port SHALL hold their last value; only valids gate use.
REQ-029 mem_data_valid_I outside DATA SHALL be ignored.

Reset
REQ-030 While rst = 0: state IDLE, last_grant = 1 (port 0 wins first tie), discard = 0, owner = 0, all valid and ready outputs 0, address/data registers 0.
REQ-031 Reset assertion mid-transaction SHALL abandon it immediately; no response is produced after release.

Verification
REQ-032 Reset, then idle with no requests: all valid and ready outputs 0 for 3 cycles; grant_O = 0.
REQ-033 Port 0 only, addr 0x00, mem returns 0xDEADBEEF in zero wait states: rsp0_valid_O = 1 with 0xDEADBEEF two edges after request accept; rsp1_valid_O never 1.
REQ-034 Both ports request continuously (0x10 on port 0, 0x20 on port 1): mem_addr_O sequence 0x10, 0x20, 0x10, 0x20 with strict alternation.
REQ-035 mem_addr_ready_I held 0 for 3 cycles: mem_addr_valid_O and mem_addr_O stable throughout; then normal completion.
REQ-036 flush0_I pulsed in DATA for port 0 read: no rsp0_valid_O; FSM IDLE one edge after mem data accepted; next tie goes to port 1.
REQ-037 rst driven to 0 in RESP with rsp1_ready_I = 0: rsp1_valid_O falls without a clock edge; no response after release.

Source files
------------

// File: rtl/jpc_memarb.sv
// rtl/jpc_memarb.sv - two-port round-robin read arbiter onto a single memory port
module jpc_memarb #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] req0_addr_I,
  input  logic                     req0_valid_I,
  output logic                     req0_ready_O,
  output logic [DATA_WIDTH-1:0]    rsp0_data_O,
  output logic                     rsp0_valid_O,
  input  logic                     rsp0_ready_I,
  input  logic                     flush0_I,
  input  logic [ADDRESS_WIDTH-1:0] req1_addr_I,
  input  logic                     req1_valid_I,
  output logic                     req1_ready_O,
  output logic [DATA_WIDTH-1:0]    rsp1_data_O,
  output logic                     rsp1_valid_O,
  input  logic                     rsp1_ready_I,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_O,
  output logic                     mem_addr_valid_O,
  input  logic                     mem_addr_ready_I,
  input  logic [DATA_WIDTH-1:0]    mem_data_I,
  input  logic                     mem_data_valid_I,
  output logic                     mem_data_ready_O,
  output logic                     grant_O
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                   state_q, state_d;
  logic                     owner_q, last_grant_q, discard_q, discard_d;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    rsp0_q, rsp1_q;
  logic                     win, accept, capture, done;
  logic                     v0, flush_own;

  // a redirect on port 0 hides its request for the current cycle
  assign v0        = req0_valid_I & ~flush0_I;
  assign flush_own = flush0_I & ~owner_q;

  always_comb begin
    state_d          = state_q;
    discard_d        = discard_q;
    win              = 1'b0;
    accept           = 1'b0;
    capture          = 1'b0;
    done             = 1'b0;
    req0_ready_O     = 1'b0;
    req1_ready_O     = 1'b0;
    mem_addr_valid_O = 1'b0;
    mem_data_ready_O = 1'b0;
    rsp0_valid_O     = 1'b0;
    rsp1_valid_O     = 1'b0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (v0 && req1_valid_I) win = ~last_grant_q;
          else                    win = req1_valid_I;
          req0_ready_O = v0 & ~win;
          req1_ready_O = req1_valid_I & win;
          if (v0 || req1_valid_I) begin
            accept  = 1'b1;
            state_d = ADDR;
          end
        end
        ADDR: begin
          mem_addr_valid_O = 1'b1;
          if (flush_own) discard_d = 1'b1;
          if (mem_addr_ready_I) state_d = DATA;
        end
        DATA: begin
          mem_data_ready_O = 1'b1;
          if (flush_own) discard_d = 1'b1;
          if (mem_data_valid_I) begin
            if (discard_d) begin
              state_d   = IDLE;
              done      = 1'b1;
              discard_d = 1'b0;
            end else begin
              capture = 1'b1;
              state_d = RESP;
            end
          end
        end
        RESP: begin
          rsp0_valid_O = ~owner_q & ~flush0_I;
          rsp1_valid_O = owner_q;
          if (flush_own || (owner_q ? rsp1_ready_I : rsp0_ready_I)) begin
            state_d = IDLE;
            done    = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      discard_q    <= 1'b0;
      addr_q       <= '0;
      rsp0_q       <= '0;
      rsp1_q       <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      if (accept) begin
        owner_q <= win;
        addr_q  <= win ? req1_addr_I : req0_addr_I;
      end
      // per-port response registers keep the idle port's data stable
      if (capture) begin
        if (owner_q) rsp1_q <= mem_data_I;
        else         rsp0_q <= mem_data_I;
      end
      if (done) last_grant_q <= owner_q;
    end
  end

  assign mem_addr_O  = addr_q;
  assign rsp0_data_O = rsp0_q;
  assign rsp1_data_O = rsp1_q;
  assign grant_O     = owner_q;

endmodule

// File: tb/tb_jpc_memarb.sv
// tb/tb_jpc_memarb.sv - self-checking bench for jpc_memarb
module tb_jpc_memarb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] req0_addr_I, req1_addr_I, mem_addr_O, mem_data_I;
  logic [31:0] rsp0_data_O, rsp1_data_O;
  logic        req0_valid_I, req0_ready_O, rsp0_valid_O, rsp0_ready_I, flush0_I;
  logic        req1_valid_I, req1_ready_O, rsp1_valid_O, rsp1_ready_I;
  logic        mem_addr_valid_O, mem_addr_ready_I, mem_data_valid_I, mem_data_ready_O;
  logic        grant_O;

  int tot = 0;
  int pass = 0;

  jpc_memarb #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_addr_I(req0_addr_I), .req0_valid_I(req0_valid_I), .req0_ready_O(req0_ready_O),
    .rsp0_data_O(rsp0_data_O), .rsp0_valid_O(rsp0_valid_O), .rsp0_ready_I(rsp0_ready_I),
    .flush0_I(flush0_I),
    .req1_addr_I(req1_addr_I), .req1_valid_I(req1_valid_I), .req1_ready_O(req1_ready_O),
    .rsp1_data_O(rsp1_data_O), .rsp1_valid_O(rsp1_valid_O), .rsp1_ready_I(rsp1_ready_I),
    .mem_addr_O(mem_addr_O), .mem_addr_valid_O(mem_addr_valid_O), .mem_addr_ready_I(mem_addr_ready_I),
    .mem_data_I(mem_data_I), .mem_data_valid_I(mem_data_valid_I), .mem_data_ready_O(mem_data_ready_O),
    .grant_O(grant_O)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_addr_I = '0; req0_valid_I = 0; rsp0_ready_I = 0; flush0_I = 0;
    req1_addr_I = '0; req1_valid_I = 0; rsp1_ready_I = 0;
    mem_addr_ready_I = 0; mem_data_I = '0; mem_data_valid_I = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    clear_inputs();
    step();
    step();
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    clear_inputs();
    req0_valid_I = 1; req1_valid_I = 1;
    #1;
    tot++;
    if ({req0_ready_O, req1_ready_O} !== 2'b00)
      $display("FAIL reset_req_ready: got %b want 00", {req0_ready_O, req1_ready_O});
    else pass++;
    step();
    clear_inputs();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      tot++;
      if ({req0_ready_O, req1_ready_O, mem_addr_valid_O, mem_data_ready_O, rsp0_valid_O, rsp1_valid_O} !== 6'b0)
        $display("FAIL idle_handshakes cycle %0d: got %b want 000000", i,
                 {req0_ready_O, req1_ready_O, mem_addr_valid_O, mem_data_ready_O, rsp0_valid_O, rsp1_valid_O});
      else pass++;
      tot++;
      if (grant_O !== 1'b0) $display("FAIL idle_grant: got %b want 0", grant_O);
      else pass++;
    end
    tot++;
    if ({rsp0_data_O, rsp1_data_O, mem_addr_O} !== 96'h0)
      $display("FAIL reset_regs: got %h %h %h want zero", rsp0_data_O, rsp1_data_O, mem_addr_O);
    else pass++;
  endtask

  task automatic test_single_port0();
    do_reset();
    mem_addr_ready_I = 1; mem_data_valid_I = 1; mem_data_I = 32'hDEADBEEF; rsp0_ready_I = 1;
    req0_addr_I = 32'h0; req0_valid_I = 1;
    #1;
    tot++;
    if (req0_ready_O !== 1'b1) $display("FAIL single_accept: got %b want 1", req0_ready_O);
    else pass++;
    step();
    req0_valid_I = 0;
    #1;
    tot++;
    if ({mem_addr_valid_O, mem_addr_O} !== {1'b1, 32'h0})
      $display("FAIL single_addr: got %b/%h want 1/00000000", mem_addr_valid_O, mem_addr_O);
    else pass++;
    step();
    tot++;
    if ({mem_data_ready_O, rsp0_valid_O} !== 2'b10)
      $display("FAIL single_data_phase: got %b want 10", {mem_data_ready_O, rsp0_valid_O});
    else pass++;
    step();
    tot++;
    if ({rsp0_valid_O, rsp1_valid_O, rsp0_data_O} !== {2'b10, 32'hDEADBEEF})
      $display("FAIL single_resp: got %b%b/%h want 10/deadbeef", rsp0_valid_O, rsp1_valid_O, rsp0_data_O);
    else pass++;
    step();
    tot++;
    if ({rsp0_valid_O, rsp1_valid_O} !== 2'b00)
      $display("FAIL single_resp_end: got %b want 00", {rsp0_valid_O, rsp1_valid_O});
    else pass++;
    clear_inputs();
  endtask

  task automatic test_alternation();
    logic [31:0] seen [4];
    logic [31:0] want [4];
    int n;
    want[0] = 32'h10; want[1] = 32'h20; want[2] = 32'h10; want[3] = 32'h20;
    n = 0;
    do_reset();
    mem_addr_ready_I = 1; mem_data_valid_I = 1; mem_data_I = 32'h55; rsp0_ready_I = 1; rsp1_ready_I = 1;
    req0_addr_I = 32'h10; req0_valid_I = 1; req1_addr_I = 32'h20; req1_valid_I = 1;
    for (int c = 0; c < 40 && n < 4; c++) begin
      #1;
      if (mem_addr_valid_O && mem_addr_ready_I) begin
        seen[n] = mem_addr_O;
        n++;
      end
      step();
    end
    tot++;
    if (n != 4) $display("FAIL alt_count: got %0d want 4", n);
    else pass++;
    for (int i = 0; i < n; i++) begin
      tot++;
      if (seen[i] !== want[i]) $display("FAIL alt_seq[%0d]: got %h want %h", i, seen[i], want[i]);
      else pass++;
    end
    clear_inputs();
  endtask

  task automatic test_addr_stall();
    do_reset();
    req1_addr_I = 32'h1234; req1_valid_I = 1;
    #1;
    tot++;
    if (req1_ready_O !== 1'b1) $display("FAIL stall_accept: got %b want 1", req1_ready_O);
    else pass++;
    step();
    req1_valid_I = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_addr_ready_I = 1;
      #1;
      tot++;
      if ({mem_addr_valid_O, mem_addr_O} !== {1'b1, 32'h1234})
        $display("FAIL stall_addr cycle %0d: got %b/%h want 1/00001234", i, mem_addr_valid_O, mem_addr_O);
      else pass++;
      step();
    end
    mem_addr_ready_I = 0; mem_data_valid_I = 1; mem_data_I = 32'hCAFEF00D;
    #1;
    tot++;
    if (mem_data_ready_O !== 1'b1) $display("FAIL stall_data_ready: got %b want 1", mem_data_ready_O);
    else pass++;
    step();
    mem_data_valid_I = 0; rsp1_ready_I = 1;
    #1;
    tot++;
    if ({rsp1_valid_O, rsp0_valid_O, grant_O, rsp1_data_O} !== {3'b101, 32'hCAFEF00D})
      $display("FAIL stall_resp: got %b%b%b/%h want 101/cafef00d", rsp1_valid_O, rsp0_valid_O, grant_O, rsp1_data_O);
    else pass++;
    step();
    tot++;
    if (rsp1_valid_O !== 1'b0) $display("FAIL stall_resp_end: got %b want 0", rsp1_valid_O);
    else pass++;
    clear_inputs();
  endtask

  task automatic test_flush_data();
    do_reset();
    req0_addr_I = 32'h40; req0_valid_I = 1; mem_addr_ready_I = 1; rsp0_ready_I = 1;
    step();
    req0_valid_I = 0;
    step();
    mem_addr_ready_I = 0; flush0_I = 1;
    #1;
    tot++;
    if ({mem_data_ready_O, rsp0_valid_O} !== 2'b10)
      $display("FAIL flush_in_data: got %b want 10", {mem_data_ready_O, rsp0_valid_O});
    else pass++;
    step();
    flush0_I = 0; mem_data_valid_I = 1; mem_data_I = 32'h11112222;
    #1;
    tot++;
    if ({mem_data_ready_O, rsp0_valid_O} !== 2'b10)
      $display("FAIL flush_data_accept: got %b want 10", {mem_data_ready_O, rsp0_valid_O});
    else pass++;
    step();
    mem_data_valid_I = 0;
    req0_valid_I = 1; flush0_I = 1;
    #1;
    tot++;
    if ({rsp0_valid_O, req0_ready_O} !== 2'b00)
      $display("FAIL flush_idle_suppress: got %b want 00", {rsp0_valid_O, req0_ready_O});
    else pass++;
    flush0_I = 0; req1_addr_I = 32'h80; req1_valid_I = 1;
    #1;
    tot++;
    if ({req0_ready_O, req1_ready_O} !== 2'b01)
      $display("FAIL flush_next_tie: got %b want 01", {req0_ready_O, req1_ready_O});
    else pass++;
    clear_inputs();
  endtask

  task automatic test_reset_in_resp();
    do_reset();
    req1_addr_I = 32'h300; req1_valid_I = 1; mem_addr_ready_I = 1; mem_data_valid_I = 1; mem_data_I = 32'h77;
    step();
    req1_valid_I = 0;
    step();
    step();
    tot++;
    if (rsp1_valid_O !== 1'b1) $display("FAIL rst_resp_before: got %b want 1", rsp1_valid_O);
    else pass++;
    rst = 0;
    #1;
    tot++;
    if (rsp1_valid_O !== 1'b0) $display("FAIL rst_resp_async: got %b want 0", rsp1_valid_O);
    else pass++;
    step();
    step();
    rst = 1;
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      step();
      tot++;
      if ({rsp0_valid_O, rsp1_valid_O, mem_addr_valid_O, mem_data_ready_O} !== 4'b0)
        $display("FAIL rst_no_resp cycle %0d: got %b want 0000", i,
                 {rsp0_valid_O, rsp1_valid_O, mem_addr_valid_O, mem_data_ready_O});
      else pass++;
    end
  endtask

  task automatic test_random();
    bit h0, h1, busy, own, adone, pend, inresp, last, w, acc, ah, dh, rh;
    logic [31:0] a0, a1, eaddr, m0, m1;
    h0 = 0; h1 = 0; busy = 0; own = 0; adone = 0; pend = 0; inresp = 0; last = 1;
    a0 = '0; a1 = '0; eaddr = '0; m0 = '0; m1 = '0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (!h0 && $urandom_range(0, 2) == 0) begin h0 = 1; a0 = $urandom; end
      if (!h1 && $urandom_range(0, 2) == 0) begin h1 = 1; a1 = $urandom; end
      req0_valid_I = h0; req0_addr_I = a0;
      req1_valid_I = h1; req1_addr_I = a1;
      mem_addr_ready_I = 1'($urandom_range(0, 1));
      mem_data_valid_I = 1'($urandom_range(0, 1));
      mem_data_I = pend ? mem_fn(eaddr) : $urandom;
      rsp0_ready_I = 1'($urandom_range(0, 1));
      rsp1_ready_I = 1'($urandom_range(0, 1));
      #1;
      w = (h0 && h1) ? ~last : h1;
      acc = !busy && (h0 || h1);
      tot++;
      if ({req0_ready_O, req1_ready_O} !== {acc && !w, acc && w})
        $display("FAIL rnd_req_ready cycle %0d: got %b want %b", c, {req0_ready_O, req1_ready_O}, {acc && !w, acc && w});
      else pass++;
      tot++;
      if (mem_addr_valid_O !== (busy && !adone))
        $display("FAIL rnd_addr_valid cycle %0d: got %b want %b", c, mem_addr_valid_O, busy && !adone);
      else pass++;
      if (busy && !adone) begin
        tot++;
        if (mem_addr_O !== eaddr) $display("FAIL rnd_addr cycle %0d: got %h want %h", c, mem_addr_O, eaddr);
        else pass++;
      end
      tot++;
      if (mem_data_ready_O !== pend) $display("FAIL rnd_data_ready cycle %0d: got %b want %b", c, mem_data_ready_O, pend);
      else pass++;
      tot++;
      if ({rsp0_valid_O, rsp1_valid_O} !== {inresp && !own, inresp && own})
        $display("FAIL rnd_rsp_valid cycle %0d: got %b want %b", c, {rsp0_valid_O, rsp1_valid_O}, {inresp && !own, inresp && own});
      else pass++;
      tot++;
      if ({rsp0_data_O, rsp1_data_O} !== {m0, m1})
        $display("FAIL rnd_rsp_data cycle %0d: got %h %h want %h %h", c, rsp0_data_O, rsp1_data_O, m0, m1);
      else pass++;
      if (busy) begin
        tot++;
        if (grant_O !== own) $display("FAIL rnd_grant cycle %0d: got %b want %b", c, grant_O, own);
        else pass++;
      end
      ah = busy && !adone && mem_addr_ready_I;
      dh = pend && mem_data_valid_I;
      rh = inresp && (own ? rsp1_ready_I : rsp0_ready_I);
      if (acc) begin
        busy = 1; own = w; eaddr = w ? a1 : a0; adone = 0;
        if (w) h1 = 0; else h0 = 0;
      end
      if (ah) begin adone = 1; pend = 1; end
      if (dh) begin
        pend = 0; inresp = 1;
        if (own) m1 = mem_fn(eaddr); else m0 = mem_fn(eaddr);
      end
      if (rh) begin inresp = 0; busy = 0; last = own; end
      step();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_port0();
    test_alternation();
    test_addr_stall();
    test_flush_data();
    test_reset_in_resp();
    test_random();
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end

endmodule
